// File: rtl/spi_wb_sequencer.sv
// Wishbone master that initialises a simple_spi_top core and then runs one
// write-SPDR / poll-SPSR / read-SPDR sequence per byte taken from a tx stream.
module spi_wb_sequencer #(
    parameter logic [7:0]  SPCR_INIT  = 8'h50,
    parameter logic [7:0]  SPER_INIT  = 8'h00,
    parameter logic [15:0] POLL_LIMIT = 16'd1023
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    input  logic       wb_ack_i,
    output logic       init_done_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam logic [7:0] ADR_SPCR = 8'd0;
    localparam logic [7:0] ADR_SPSR = 8'd1;
    localparam logic [7:0] ADR_SPDR = 8'd2;
    localparam logic [7:0] ADR_SPER = 8'd3;

    typedef enum logic [2:0] {
        INIT_SPER,
        INIT_SPCR,
        IDLE,
        WR_DAT,
        POLL_SR,
        RD_DAT,
        HOLD_RX,
        TIMEOUT
    } state_e;

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic [7:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic        we_q, we_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_ready_q, tx_ready_d;
    logic        init_done_q, init_done_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;

    // Per-state access request; the shared logic below turns it into a bus cycle.
    logic        acc_req;
    logic        acc_done;
    logic [7:0]  acc_adr;
    logic [7:0]  acc_dat;
    logic        acc_we;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        tx_byte_d   = tx_byte_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        tx_ready_d  = tx_ready_q;
        init_done_d = init_done_q;
        poll_cnt_d  = poll_cnt_q;
        timeout_d   = 1'b0;
        acc_req     = 1'b0;
        acc_adr     = 8'd0;
        acc_dat     = 8'd0;
        acc_we      = 1'b0;
        acc_done    = cyc_q & wb_ack_i;

        case (state_q)
            INIT_SPER: begin
                acc_req = 1'b1;
                acc_adr = ADR_SPER;
                acc_dat = SPER_INIT;
                acc_we  = 1'b1;
                if (acc_done) state_d = INIT_SPCR;
            end
            INIT_SPCR: begin
                acc_req = 1'b1;
                acc_adr = ADR_SPCR;
                acc_dat = SPCR_INIT;
                acc_we  = 1'b1;
                if (acc_done) begin
                    init_done_d = 1'b1;
                    tx_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (tx_valid_i && tx_ready_q) begin
                    tx_byte_d  = tx_data_i;
                    tx_ready_d = 1'b0;
                    state_d    = WR_DAT;
                end
            end
            WR_DAT: begin
                acc_req = 1'b1;
                acc_adr = ADR_SPDR;
                acc_dat = tx_byte_q;
                acc_we  = 1'b1;
                if (acc_done) begin
                    poll_cnt_d = POLL_LIMIT;
                    state_d    = POLL_SR;
                end
            end
            POLL_SR: begin
                acc_req = 1'b1;
                acc_adr = ADR_SPSR;
                // Bit 0 of SPSR is RFEMPTY; staying in this state re-issues the read.
                if (acc_done) begin
                    if (!wb_dat_i[0]) begin
                        state_d = RD_DAT;
                    end else begin
                        poll_cnt_d = poll_cnt_q - 16'd1;
                        if (poll_cnt_q == 16'd1) begin
                            timeout_d = 1'b1;
                            state_d   = TIMEOUT;
                        end
                    end
                end
            end
            RD_DAT: begin
                acc_req = 1'b1;
                acc_adr = ADR_SPDR;
                if (acc_done) begin
                    rx_data_d  = wb_dat_i;
                    rx_valid_d = 1'b1;
                    state_d    = HOLD_RX;
                end
            end
            HOLD_RX: begin
                if (rx_valid_q && rx_ready_i) begin
                    rx_valid_d = 1'b0;
                    tx_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            TIMEOUT: begin
                tx_ready_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = INIT_SPER;
        endcase

        // Ack ends the access; the following cycle is always idle on the bus.
        if (acc_done) begin
            cyc_d = 1'b0;
            adr_d = 8'd0;
            dat_d = 8'd0;
            we_d  = 1'b0;
        end else if (acc_req && !cyc_q) begin
            cyc_d = 1'b1;
            adr_d = acc_adr;
            dat_d = acc_dat;
            we_d  = acc_we;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= INIT_SPER;
            cyc_q       <= 1'b0;
            adr_q       <= 8'd0;
            dat_q       <= 8'd0;
            we_q        <= 1'b0;
            tx_byte_q   <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            poll_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            tx_byte_q   <= tx_byte_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            poll_cnt_q  <= poll_cnt_d;
        end
    end

    assign tx_ready_o  = tx_ready_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_we_o     = we_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign init_done_o = init_done_q;
    assign busy_o      = busy_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Bench for spi_wb_sequencer: scripted simple_spi slave, transaction-level
// model of expected bus accesses / rx bytes / timeouts, per-cycle protocol checks.
module tb_spi_wb_sequencer;

    localparam int LIM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready;
    logic [7:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_ack_i;
    logic       init_done_o;
    logic       busy_o;
    logic       timeout_o;

    always #5 clk = ~clk;

    spi_wb_sequencer #(
        .SPCR_INIT (8'h50),
        .SPER_INIT (8'h00),
        .POLL_LIMIT(16'(LIM))
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_ack_i   (wb_ack_i),
        .init_done_o(init_done_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    // Slave: registered ack like simple_spi_top, read data from scripts.
    logic [7:0] sq_sr[$];
    logic [7:0] sq_dr[$];
    logic       s_ack;
    logic [7:0] s_rdat;
    logic       stray;

    assign wb_ack_i = s_ack | stray;
    assign wb_dat_i = s_rdat;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ack  <= 1'b0;
            s_rdat <= 8'h00;
        end else begin
            s_ack <= wb_cyc_o & wb_stb_o & ~s_ack;
            if (wb_cyc_o && wb_stb_o && !s_ack && !wb_we_o) begin
                if (wb_adr_o == 8'd1) begin
                    if (sq_sr.size() != 0) s_rdat <= sq_sr.pop_front();
                    else                   s_rdat <= 8'h05;
                end else if (wb_adr_o == 8'd2) begin
                    if (sq_dr.size() != 0) s_rdat <= sq_dr.pop_front();
                    else                   s_rdat <= 8'hEE;
                end else begin
                    s_rdat <= 8'h00;
                end
            end
        end
    end

    // Model state
    typedef struct {
        bit         is_to;
        logic [7:0] data;
        int         lat;
    } ev_t;

    logic [16:0] trq[$];   // {we, adr, wr_dat}; reads expect dat_o == 0
    ev_t         evq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
        end
    endtask

    // Monitor / compare process
    int          cycle = 0;
    int          hs_cycle = 0, rel_cycle = 0, last_lat = 0;
    int          spsr_reads = 0, to_count = 0, rx_count = 0;
    logic [7:0]  last_rxd = 8'h00;
    bit          armed = 1'b0;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial begin : monitor
        ev_t        ev;
        logic       p_cyc = 0, p_ack = 0, p_we = 0, p_rxv = 0, p_rxr = 0, p_to = 0, p_init = 0, p_rst = 1;
        logic [7:0] p_adr = 0, p_dat = 0, p_rxd = 0;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (rst) begin
                    chk("reset_outputs", {tx_ready_o, rx_valid_o, rx_data_o, wb_adr_o, wb_dat_o,
                        wb_we_o, wb_cyc_o, wb_stb_o, init_done_o, busy_o, timeout_o}, 32'd0);
                end else begin
                    if (p_rst) rel_cycle = cycle;
                    chk("stb_eq_cyc", wb_stb_o, wb_cyc_o);
                    if (p_cyc && !p_ack)
                        chk("wb_hold", {wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o}, {1'b1, p_we, p_adr, p_dat});
                    if (p_cyc && p_ack) chk("wb_drop_after_ack", wb_cyc_o, 1'b0);
                    if (wb_cyc_o && !wb_we_o) chk("read_dat_o_zero", wb_dat_o, 8'd0);
                    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                        if (trq.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL unexpected_access: got we=%0b adr=%0h dat=%0h, required none",
                                     wb_we_o, wb_adr_o, wb_dat_o);
                        end else begin
                            chk("wb_access", {wb_we_o, wb_adr_o, wb_dat_o}, trq.pop_front());
                        end
                        if (!wb_we_o && wb_adr_o == 8'd1) spsr_reads++;
                    end
                    if (!p_rst) chk("busy_vs_ready", busy_o, !tx_ready_o);
                    if (tx_valid && tx_ready_o) hs_cycle = cycle;
                    if (p_init) chk("init_done_sticky", init_done_o, 1'b1);
                    if (init_done_o && !p_init) chk("init_latency", cycle - rel_cycle, 6);
                    if (p_rxv && !p_rxr) chk("rx_hold", {rx_valid_o, rx_data_o}, {1'b1, p_rxd});
                    if (p_rxv && p_rxr) chk("rx_release", {rx_valid_o, tx_ready_o}, 2'b01);
                    if (rx_valid_o) chk("hold_quiet", {wb_cyc_o, tx_ready_o}, 2'b00);
                    if (rx_valid_o && !p_rxv) begin
                        rx_count++;
                        last_rxd = rx_data_o;
                        last_lat = cycle - hs_cycle;
                        if (evq.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL unexpected_rx: got %0h, required no rx", rx_data_o);
                        end else begin
                            ev = evq.pop_front();
                            chk("rx_not_timeout", ev.is_to, 1'b0);
                            chk("rx_data", rx_data_o, ev.data);
                            chk("rx_latency", last_lat, ev.lat);
                        end
                    end
                    if (timeout_o) begin
                        to_count++;
                        chk("timeout_one_cycle", p_to, 1'b0);
                        chk("timeout_no_rx", rx_valid_o, 1'b0);
                        if (evq.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL unexpected_timeout: got pulse, required none");
                        end else begin
                            ev = evq.pop_front();
                            chk("timeout_expected", ev.is_to, 1'b1);
                        end
                    end
                end
            end
            p_cyc  = wb_cyc_o;  p_ack = wb_ack_i;  p_we  = wb_we_o;
            p_adr  = wb_adr_o;  p_dat = wb_dat_o;  p_rxv = rx_valid_o;
            p_rxr  = rx_ready;  p_rxd = rx_data_o; p_to  = timeout_o;
            p_init = init_done_o; p_rst = rst;
        end
    end

    // Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return tx_ready_o == 1'b1;
            1:       return init_done_o == 1'b1;
            2:       return spsr_reads == 1 && wb_stb_o && wb_adr_o == 8'd1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name);
        int n = 0;
        while (!cond(sel) && n < 300) begin
            tick();
            n++;
        end
        if (!cond(sel)) begin
            n_tests++; n_fail++;
            $display("FAIL %s: condition not reached within %0d cycles", name, n);
        end
    endtask

    // Model: SPSR reports empty n_empty times, then sr_ok; read count capped at LIM.
    task automatic send_byte(input logic [7:0] b, input int n_empty,
                             input logic [7:0] sr_ok, input logic [7:0] spdr);
        bit to = (n_empty >= LIM);
        int p  = to ? LIM : n_empty + 1;
        trq.push_back({1'b1, 8'd2, b});
        for (int i = 0; i < p; i++) trq.push_back({1'b0, 8'd1, 8'd0});
        if (!to) begin
            trq.push_back({1'b0, 8'd2, 8'd0});
            evq.push_back('{is_to: 1'b0, data: spdr, lat: 3 * (2 + p) + 1});
        end else begin
            evq.push_back('{is_to: 1'b1, data: 8'h00, lat: -1});
        end
        for (int i = 0; i < n_empty; i++) sq_sr.push_back(8'h05);
        if (!to) begin
            sq_sr.push_back(sr_ok);
            sq_dr.push_back(spdr);
        end
        tx_data  = b;
        tx_valid = 1'b1;
        wait_for(0, "tx_accept");
        tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {tx_ready_o, rx_valid_o, rx_data_o, wb_adr_o, wb_dat_o,
            wb_we_o, wb_cyc_o, wb_stb_o, init_done_o, busy_o, timeout_o}, 32'd0);
        trq.delete(); evq.delete(); sq_sr.delete(); sq_dr.delete();
        tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        trq.push_back({1'b1, 8'd3, 8'h00});
        trq.push_back({1'b1, 8'd0, 8'h50});
    endtask

    initial begin : watchdog
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int rx0, to0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; stray = 1'b0;
        #1 rst = 1'b1;
        armed = 1'b1;

        // Reset and init
        @(posedge clk); #3;
        apply_reset();
        wait_for(1, "init_done");
        tick();
        chk("init_ready", {init_done_o, tx_ready_o}, 2'b11);
        chk("init_queue_drained", trq.size(), 0);

        // Stray ack while idle is ignored
        stray = 1'b1; tick(); stray = 1'b0; tick();
        chk("stray_ack_ignored", {tx_ready_o, busy_o, wb_cyc_o}, 3'b100);

        // Single byte with rx backpressure
        spsr_reads = 0;
        send_byte(8'hA5, 2, 8'h04, 8'h3C);
        tx_valid = 1'b0;
        while (!rx_valid_o && spsr_reads < 20) tick();
        tick();
        chk("single_rx_data", rx_data_o, 8'h3C);
        chk("single_spsr_reads", spsr_reads, 3);
        chk("single_latency", last_lat, 16);
        repeat (20) tick();
        chk("backpressure_stable", {rx_valid_o, rx_data_o, tx_ready_o}, {1'b1, 8'h3C, 1'b0});
        rx_ready = 1'b1;
        tick();
        chk("ready_after_rx_hs", tx_ready_o, 1'b1);

        // Boundary: data ready on the last permitted poll
        spsr_reads = 0; rx0 = rx_count;
        send_byte(8'h5A, LIM - 1, 8'h04, 8'hC3);
        tx_valid = 1'b0;
        wait_for(0, "idle_after_last_poll");
        chk("last_poll_reads", spsr_reads, 4);
        chk("last_poll_rx", {rx_count - rx0, 24'd0, last_rxd}, {32'd1, 24'd0, 8'hC3});

        // Timeout, then a normal byte
        spsr_reads = 0; rx0 = rx_count; to0 = to_count;
        send_byte(8'h77, LIM, 8'h04, 8'h00);
        tx_valid = 1'b0;
        wait_for(0, "idle_after_timeout");
        chk("timeout_reads", spsr_reads, 4);
        chk("timeout_pulses", to_count - to0, 1);
        chk("timeout_no_rx_count", rx_count - rx0, 0);
        send_byte(8'h11, 0, 8'h04, 8'h22);
        tx_valid = 1'b0;
        wait_for(0, "idle_after_recovery");
        chk("after_timeout_rx", last_rxd, 8'h22);

        // Back-to-back with rx_ready tied high
        rx0 = rx_count;
        send_byte(8'h01, 0, 8'hFE, 8'h81);
        send_byte(8'h02, 1, 8'hFE, 8'h82);
        send_byte(8'h03, 0, 8'hFE, 8'h83);
        tx_valid = 1'b0;
        wait_for(0, "idle_after_stream");
        chk("stream_count", rx_count - rx0, 3);
        chk("stream_last", last_rxd, 8'h83);

        // Reset while an SPSR read is in flight
        spsr_reads = 0; rx0 = rx_count;
        send_byte(8'h99, 3, 8'h04, 8'h66);
        wait_for(2, "second_poll_stb");
        apply_reset();
        wait_for(1, "reinit_done");
        tick();
        chk("reinit_queue_drained", trq.size(), 0);
        chk("aborted_no_rx", rx_count - rx0, 0);
        send_byte(8'h44, 0, 8'h04, 8'h55);
        tx_valid = 1'b0;
        wait_for(0, "idle_after_reinit");
        chk("post_reset_rx", last_rxd, 8'h55);

        repeat (3) tick();
        chk("trans_queue_empty", trq.size(), 0);
        chk("event_queue_empty", evq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
